// File: rtl/seq_detect_param.sv
// Parametrised serial sequence detector with KMP-style transitions built at elaboration,
// selectable overlap and Moore/Mealy output, plus a saturating detection counter.
module seq_detect_param #(
  parameter int unsigned              PATTERN_LEN = 5,
  parameter logic [PATTERN_LEN-1:0]   PATTERN     = 5'b11011,
  parameter bit                       OVERLAP     = 1'b1,
  parameter bit                       MOORE       = 1'b1,
  parameter int unsigned              CNT_W       = 8,
  localparam int unsigned             SW          = $clog2(PATTERN_LEN + 1)
) (
  input  logic             clk_pulse,
  input  logic             clear,
  input  logic             inp_1,
  input  logic             inp_valid,
  input  logic             sync_clr,
  output logic             out,
  output logic [SW-1:0]    present_state,
  output logic [CNT_W-1:0] match_count
);

  localparam int unsigned    NumEnt = 2 ** SW;
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  if (PATTERN_LEN < 2 || PATTERN_LEN > 16) begin : g_bad_len
    $error("seq_detect_param: PATTERN_LEN must be in 2..16");
  end

  // Bit idx of the pattern in arrival order (idx 0 is the first bit received).
  function automatic logic pat_bit(input int unsigned idx);
    return PATTERN[PATTERN_LEN-1-idx];
  endfunction

  // Longest proper prefix of prefix_k that is also its suffix.
  function automatic int unsigned fail_f(input int unsigned k);
    int unsigned res;
    logic        ok;
    res = 0;
    for (int unsigned m = 1; m < k; m++) begin
      ok = 1'b1;
      for (int unsigned j = 0; j < m; j++) begin
        if (pat_bit(k - m + j) != pat_bit(j)) ok = 1'b0;
      end
      if (ok) res = m;
    end
    return res;
  endfunction

  // Longest prefix that is a suffix of prefix_k followed by bit b (k < PATTERN_LEN).
  function automatic int unsigned delta_f(input int unsigned k, input logic b);
    int unsigned res;
    int unsigned idx;
    logic        ok;
    logic        sb;
    res = 0;
    for (int unsigned m = 1; m <= k + 1; m++) begin
      ok = 1'b1;
      for (int unsigned j = 0; j < m; j++) begin
        idx = k + 1 - m + j;
        sb  = (idx == k) ? b : pat_bit(idx);
        if (sb != pat_bit(j)) ok = 1'b0;
      end
      if (ok) res = m;
    end
    return res;
  endfunction

  // State to resume matching from after a completed match.
  function automatic int unsigned restart_f();
    return OVERLAP ? fail_f(PATTERN_LEN) : 0;
  endfunction

  function automatic int unsigned nxt_f(input int unsigned k, input logic b);
    int unsigned res;
    res = 0;
    if (MOORE) begin
      if (k == PATTERN_LEN) res = delta_f(restart_f(), b);
      else if (k < PATTERN_LEN) res = delta_f(k, b);
    end else if (k < PATTERN_LEN) begin
      res = delta_f(k, b);
      if (res == PATTERN_LEN) res = restart_f();
    end
    return res;
  endfunction

  function automatic logic det_f(input int unsigned k, input logic b);
    logic res;
    res = 1'b0;
    if (MOORE) begin
      if (k == PATTERN_LEN) res = (delta_f(restart_f(), b) == PATTERN_LEN);
      else if (k < PATTERN_LEN) res = (delta_f(k, b) == PATTERN_LEN);
    end else if (k < PATTERN_LEN) begin
      res = (delta_f(k, b) == PATTERN_LEN);
    end
    return res;
  endfunction

  // Tables cover every encodable state; unreachable entries fall back to state 0.
  logic [NumEnt-1:0][SW-1:0] nxt_tbl0, nxt_tbl1;
  logic [NumEnt-1:0]         det_tbl0, det_tbl1;

  for (genvar k = 0; k < NumEnt; k++) begin : g_tbl
    localparam int unsigned Nxt0 = nxt_f(k, 1'b0);
    localparam int unsigned Nxt1 = nxt_f(k, 1'b1);
    localparam logic        Det0 = det_f(k, 1'b0);
    localparam logic        Det1 = det_f(k, 1'b1);
    assign nxt_tbl0[k] = SW'(Nxt0);
    assign nxt_tbl1[k] = SW'(Nxt1);
    assign det_tbl0[k] = Det0;
    assign det_tbl1[k] = Det1;
  end

  logic [SW-1:0]    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SW-1:0]    nxt_sel;
  logic             det;

  always_comb begin
    nxt_sel = inp_1 ? nxt_tbl1[state_q] : nxt_tbl0[state_q];
    det     = inp_valid & (inp_1 ? det_tbl1[state_q] : det_tbl0[state_q]);
    state_d = state_q;
    cnt_d   = cnt_q;
    if (sync_clr) begin
      state_d = '0;
      cnt_d   = '0;
    end else if (inp_valid) begin
      state_d = nxt_sel;
      if (det && (cnt_q != CntMax)) cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_pulse or posedge clear) begin
    if (clear) begin
      state_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  if (MOORE) begin : g_moore
    assign out = (state_q == SW'(PATTERN_LEN));
  end else begin : g_mealy
    assign out = ~clear & inp_valid & (state_q == SW'(PATTERN_LEN - 1)) &
                 (inp_1 == PATTERN[0]);
  end

  assign present_state = state_q;
  assign match_count   = cnt_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: several configurations share one stimulus stream; expected
// values come from hand-derived vector tables queued as a scoreboard.
module tb_seq_detect_param;

  logic clk = 1'b0;
  logic clear, inp_1, inp_valid, sync_clr;

  always #5 clk = ~clk;

  // A: 11011 Moore overlap, B: 11011 Moore no-overlap, C: 11011 Mealy overlap,
  // D: 1101 Moore overlap, E: 11 Moore overlap with 2-bit counter.
  logic       a_out, b_out, c_out, d_out, e_out;
  logic [2:0] a_st, b_st, c_st, d_st;
  logic [1:0] e_st;
  logic [7:0] a_cnt, b_cnt, c_cnt, d_cnt;
  logic [1:0] e_cnt;

  seq_detect_param u_a (
    .clk_pulse(clk), .clear(clear), .inp_1(inp_1), .inp_valid(inp_valid),
    .sync_clr(sync_clr), .out(a_out), .present_state(a_st), .match_count(a_cnt)
  );

  seq_detect_param #(.OVERLAP(1'b0)) u_b (
    .clk_pulse(clk), .clear(clear), .inp_1(inp_1), .inp_valid(inp_valid),
    .sync_clr(sync_clr), .out(b_out), .present_state(b_st), .match_count(b_cnt)
  );

  seq_detect_param #(.MOORE(1'b0)) u_c (
    .clk_pulse(clk), .clear(clear), .inp_1(inp_1), .inp_valid(inp_valid),
    .sync_clr(sync_clr), .out(c_out), .present_state(c_st), .match_count(c_cnt)
  );

  seq_detect_param #(.PATTERN_LEN(4), .PATTERN(4'b1101)) u_d (
    .clk_pulse(clk), .clear(clear), .inp_1(inp_1), .inp_valid(inp_valid),
    .sync_clr(sync_clr), .out(d_out), .present_state(d_st), .match_count(d_cnt)
  );

  seq_detect_param #(.PATTERN_LEN(2), .PATTERN(2'b11), .CNT_W(2)) u_e (
    .clk_pulse(clk), .clear(clear), .inp_1(inp_1), .inp_valid(inp_valid),
    .sync_clr(sync_clr), .out(e_out), .present_state(e_st), .match_count(e_cnt)
  );

  typedef struct {
    bit grp;  // 0: A/B/C, 1: D/E
    bit v;
    bit b;
    bit sc;
    int s0, o0, c0;
    int s1, o1, c1;
    int s2, c2;
    int mo;   // Mealy out sampled before the edge (group 0)
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic vec_t mk0(bit v, bit b, bit sc, int s0, int o0, int c0,
                               int s1, int o1, int c1, int s2, int c2, int mo);
    vec_t t;
    t.grp = 1'b0; t.v = v; t.b = b; t.sc = sc;
    t.s0 = s0; t.o0 = o0; t.c0 = c0; t.s1 = s1; t.o1 = o1; t.c1 = c1;
    t.s2 = s2; t.c2 = c2; t.mo = mo;
    return t;
  endfunction

  function automatic vec_t mk1(bit v, bit b, int s0, int o0, int c0, int s1, int o1, int c1);
    vec_t t;
    t.grp = 1'b1; t.v = v; t.b = b; t.sc = 1'b0;
    t.s0 = s0; t.o0 = o0; t.c0 = c0; t.s1 = s1; t.o1 = o1; t.c1 = c1;
    t.s2 = 0; t.c2 = 0; t.mo = 0;
    return t;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_a_st"}, int'(a_st), 0);
    chk({tag, "_a_out"}, int'(a_out), 0);
    chk({tag, "_a_cnt"}, int'(a_cnt), 0);
    chk({tag, "_b_st"}, int'(b_st), 0);
    chk({tag, "_b_cnt"}, int'(b_cnt), 0);
    chk({tag, "_c_st"}, int'(c_st), 0);
    chk({tag, "_c_out"}, int'(c_out), 0);
    chk({tag, "_c_cnt"}, int'(c_cnt), 0);
    chk({tag, "_d_st"}, int'(d_st), 0);
    chk({tag, "_d_cnt"}, int'(d_cnt), 0);
    chk({tag, "_e_st"}, int'(e_st), 0);
    chk({tag, "_e_cnt"}, int'(e_cnt), 0);
  endtask

  task automatic apply(input int idx, input vec_t t);
    vec_t e;
    string p;
    @(negedge clk);
    inp_valid = t.v;
    inp_1     = t.b;
    sync_clr  = t.sc;
    exp_q.push_back(t);
    p = $sformatf("v%0d", idx);
    #1;
    if (t.grp == 1'b0) chk({p, "_c_out"}, int'(c_out), t.mo);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    if (e.grp == 1'b0) begin
      chk({p, "_a_st"}, int'(a_st), e.s0);
      chk({p, "_a_out"}, int'(a_out), e.o0);
      chk({p, "_a_cnt"}, int'(a_cnt), e.c0);
      chk({p, "_b_st"}, int'(b_st), e.s1);
      chk({p, "_b_out"}, int'(b_out), e.o1);
      chk({p, "_b_cnt"}, int'(b_cnt), e.c1);
      chk({p, "_c_st"}, int'(c_st), e.s2);
      chk({p, "_c_cnt"}, int'(c_cnt), e.c2);
    end else begin
      chk({p, "_d_st"}, int'(d_st), e.s0);
      chk({p, "_d_out"}, int'(d_out), e.o0);
      chk({p, "_d_cnt"}, int'(d_cnt), e.c0);
      chk({p, "_e_st"}, int'(e_st), e.s1);
      chk({p, "_e_out"}, int'(e_out), e.o1);
      chk({p, "_e_cnt"}, int'(e_cnt), e.c1);
    end
  endtask

  // Async clear mid-cycle while a valid final-looking bit is presented.
  task automatic pulse_clear(input string tag);
    @(negedge clk);
    inp_valid = 1'b1;
    inp_1     = 1'b1;
    sync_clr  = 1'b0;
    #2 clear = 1'b1;
    #1;
    chk_all_zero(tag);
    @(negedge clk);
    clear     = 1'b0;
    inp_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    clear = 1'b1; inp_1 = 1'b0; inp_valid = 1'b0; sync_clr = 1'b0;

    // Group 0: stream 1,1,0,1,1,0,1,1 then gap, sync_clr on a final bit, fresh match.
    vecs.push_back(mk0(1, 1, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0));
    vecs.push_back(mk0(1, 1, 0, 2, 0, 0, 2, 0, 0, 2, 0, 0));
    vecs.push_back(mk0(1, 0, 0, 3, 0, 0, 3, 0, 0, 3, 0, 0));
    vecs.push_back(mk0(1, 1, 0, 4, 0, 0, 4, 0, 0, 4, 0, 0));
    vecs.push_back(mk0(1, 1, 0, 5, 1, 1, 5, 1, 1, 2, 1, 1));
    vecs.push_back(mk0(1, 0, 0, 3, 0, 1, 0, 0, 1, 3, 1, 0));
    vecs.push_back(mk0(1, 1, 0, 4, 0, 1, 1, 0, 1, 4, 1, 0));
    vecs.push_back(mk0(1, 1, 0, 5, 1, 2, 2, 0, 1, 2, 2, 1));
    vecs.push_back(mk0(1, 0, 0, 3, 0, 2, 3, 0, 1, 3, 2, 0));
    vecs.push_back(mk0(1, 1, 0, 4, 0, 2, 4, 0, 1, 4, 2, 0));
    vecs.push_back(mk0(0, 1, 0, 4, 0, 2, 4, 0, 1, 4, 2, 0));
    vecs.push_back(mk0(0, 1, 0, 4, 0, 2, 4, 0, 1, 4, 2, 0));
    vecs.push_back(mk0(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk0(1, 1, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0));
    vecs.push_back(mk0(1, 1, 0, 2, 0, 0, 2, 0, 0, 2, 0, 0));
    vecs.push_back(mk0(1, 0, 0, 3, 0, 0, 3, 0, 0, 3, 0, 0));
    vecs.push_back(mk0(1, 1, 0, 4, 0, 0, 4, 0, 0, 4, 0, 0));
    vecs.push_back(mk0(1, 1, 0, 5, 1, 1, 5, 1, 1, 2, 1, 1));
    vecs.push_back(mk0(1, 0, 0, 3, 0, 1, 0, 0, 1, 3, 1, 0));
    vecs.push_back(mk0(1, 1, 0, 4, 0, 1, 1, 0, 1, 4, 1, 0));
    // After a mid-sequence clear: a full fresh pattern is needed.
    vecs.push_back(mk0(1, 1, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0));
    vecs.push_back(mk0(1, 1, 0, 2, 0, 0, 2, 0, 0, 2, 0, 0));
    vecs.push_back(mk0(1, 0, 0, 3, 0, 0, 3, 0, 0, 3, 0, 0));
    vecs.push_back(mk0(1, 1, 0, 4, 0, 0, 4, 0, 0, 4, 0, 0));
    vecs.push_back(mk0(1, 1, 0, 5, 1, 1, 5, 1, 1, 2, 1, 1));
    // Group 1: D (1101) with valid gaps, E (11) saturating at 3.
    vecs.push_back(mk1(1, 1, 1, 0, 0, 1, 0, 0));
    vecs.push_back(mk1(1, 1, 2, 0, 0, 2, 1, 1));
    vecs.push_back(mk1(1, 1, 2, 0, 0, 2, 1, 2));
    vecs.push_back(mk1(0, 0, 2, 0, 0, 2, 1, 2));
    vecs.push_back(mk1(0, 1, 2, 0, 0, 2, 1, 2));
    vecs.push_back(mk1(1, 0, 3, 0, 0, 0, 0, 2));
    vecs.push_back(mk1(1, 1, 4, 1, 1, 1, 0, 2));
    vecs.push_back(mk1(0, 1, 4, 1, 1, 1, 0, 2));
    vecs.push_back(mk1(0, 0, 4, 1, 1, 1, 0, 2));
    vecs.push_back(mk1(0, 1, 4, 1, 1, 1, 0, 2));
    vecs.push_back(mk1(1, 0, 0, 0, 1, 0, 0, 2));
    vecs.push_back(mk1(1, 1, 1, 0, 1, 1, 0, 2));
    vecs.push_back(mk1(1, 1, 2, 0, 1, 2, 1, 3));
    vecs.push_back(mk1(1, 1, 2, 0, 1, 2, 1, 3));
    vecs.push_back(mk1(1, 1, 2, 0, 1, 2, 1, 3));
    vecs.push_back(mk1(1, 1, 2, 0, 1, 2, 1, 3));
    vecs.push_back(mk1(1, 1, 2, 0, 1, 2, 1, 3));

    repeat (2) @(negedge clk);
    inp_valid = 1'b1;
    inp_1     = 1'b1;
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    clear     = 1'b0;
    inp_valid = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      if (i == 20) pulse_clear("clr_mid");
      if (i == 25) pulse_clear("clr_grp1");
      apply(i, vecs[i]);
    end

    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
